// File: rtl/occ_pattern_genchk.sv
// occ_pattern_genchk: 8b/10b link test-pattern generator (K28.5 comma + counter) and locking checker.
// Optional macro OCC_PATTERN_DISPERR_EN: RX disparity/not-in-table flags force a mismatch while LOCKED.
module occ_pattern_genchk #(
  parameter int unsigned g_BYTES         = 2,
  parameter int unsigned g_COMMA_PERIOD  = 32,
  parameter int unsigned g_ERR_CNT_WIDTH = 16,
  parameter int unsigned g_LOSS_THRESH   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tx_en_i,
  output logic [8*g_BYTES-1:0]       tx_data_o,
  output logic [g_BYTES-1:0]         tx_charisk_o,
  input  logic                       rx_valid_i,
  input  logic [8*g_BYTES-1:0]       rx_data_i,
  input  logic [g_BYTES-1:0]         rx_charisk_i,
  input  logic [g_BYTES-1:0]         rx_disperr_i,
  input  logic [g_BYTES-1:0]         rx_notintable_i,
  input  logic                       clr_i,
  output logic                       locked_o,
  output logic                       err_o,
  output logic [g_ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [g_ERR_CNT_WIDTH-1:0] frame_cnt_o
);

  localparam int unsigned W = 8 * g_BYTES;
  localparam int unsigned P = $clog2(g_COMMA_PERIOD);
  localparam logic [W-1:0]       COMMA_DATA = {8'hBC, {(g_BYTES-1){8'h95}}};
  localparam logic [g_BYTES-1:0] COMMA_K    = {1'b1, {(g_BYTES-1){1'b0}}};
  localparam logic [P-1:0]       SEED_LOW   = P'(1);
  localparam logic [3:0]         LOSS_LAST  = 4'(g_LOSS_THRESH - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_SEED, ST_LOCKED} state_t;

  // Generator state
  logic [W-1:0]       g_q, g_d;
  logic [W-1:0]       tx_data_q, tx_data_d;
  logic [g_BYTES-1:0] tx_k_q, tx_k_d;

  // Checker state
  state_t                     state_q, state_d;
  logic [W-1:0]               e_q, e_d;
  logic [3:0]                 consec_q, consec_d;
  logic                       err_q, err_d;
  logic [g_ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [g_ERR_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic               rx_is_comma;
  logic               e_is_comma;
  logic [W-1:0]       exp_data;
  logic [g_BYTES-1:0] exp_k;
  logic               rx_match;
  logic               rx_line_err;

`ifdef OCC_PATTERN_DISPERR_EN
  assign rx_line_err = |(rx_disperr_i | rx_notintable_i);
`else
  logic unused_rx_flags;
  assign unused_rx_flags = ^{rx_disperr_i, rx_notintable_i};
  assign rx_line_err     = 1'b0;
`endif

  always_comb begin
    g_d       = g_q;
    tx_data_d = tx_data_q;
    tx_k_d    = tx_k_q;
    if (tx_en_i) begin
      if (g_q[P-1:0] == '0) begin
        tx_data_d = COMMA_DATA;
        tx_k_d    = COMMA_K;
      end else begin
        tx_data_d = g_q;
        tx_k_d    = '0;
      end
      g_d = g_q + 1'b1;
    end
  end

  always_comb begin
    rx_is_comma = (rx_data_i == COMMA_DATA) && (rx_charisk_i == COMMA_K);
    e_is_comma  = (e_q[P-1:0] == '0);
    exp_data    = e_is_comma ? COMMA_DATA : e_q;
    exp_k       = e_is_comma ? COMMA_K : '0;
    rx_match    = (rx_data_i == exp_data) && (rx_charisk_i == exp_k) && !rx_line_err;
  end

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    consec_d    = consec_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (rx_valid_i) begin
      unique case (state_q)
        ST_HUNT: begin
          if (rx_is_comma) state_d = ST_SEED;
        end
        ST_SEED: begin
          if ((rx_charisk_i == '0) && (rx_data_i[P-1:0] == SEED_LOW)) begin
            e_d      = rx_data_i + 1'b1;
            consec_d = '0;
            state_d  = ST_LOCKED;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // e tracks the link position, so it advances on mismatches too
          e_d = e_q + 1'b1;
          if (rx_match) begin
            consec_d = '0;
            if (e_is_comma && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (consec_q == LOSS_LAST) begin
              consec_d = '0;
              state_d  = ST_HUNT;
            end else begin
              consec_d = consec_q + 1'b1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (clr_i) begin
      err_cnt_d   = '0;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      g_q         <= '0;
      tx_data_q   <= '0;
      tx_k_q      <= '0;
      state_q     <= ST_HUNT;
      e_q         <= '0;
      consec_q    <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      g_q         <= g_d;
      tx_data_q   <= tx_data_d;
      tx_k_q      <= tx_k_d;
      state_q     <= state_d;
      e_q         <= e_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_charisk_o = tx_k_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_occ_pattern_genchk.sv
// Self-checking bench for occ_pattern_genchk: vector table, loopback, corner sequences, random vs. model.
module tb_occ_pattern_genchk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2-byte datapath, period 32, 16-bit counters
  logic        a_tx_en, a_rx_valid, a_clr, a_locked, a_err, lb;
  logic [15:0] a_tx_data, a_rx_data, a_rx_d, a_err_cnt, a_frame;
  logic [1:0]  a_tx_k, a_rx_k, a_rx_kd, a_disperr, a_nit;

  assign a_rx_data = lb ? a_tx_data : a_rx_d;
  assign a_rx_k    = lb ? a_tx_k : a_rx_kd;

  occ_pattern_genchk dut_a (
    .clk_i(clk), .rst_i(rst), .tx_en_i(a_tx_en), .tx_data_o(a_tx_data), .tx_charisk_o(a_tx_k),
    .rx_valid_i(a_rx_valid), .rx_data_i(a_rx_data), .rx_charisk_i(a_rx_k),
    .rx_disperr_i(a_disperr), .rx_notintable_i(a_nit), .clr_i(a_clr),
    .locked_o(a_locked), .err_o(a_err), .err_cnt_o(a_err_cnt), .frame_cnt_o(a_frame)
  );

  // Instance B: 4-byte datapath, period 8, 4-bit counters
  logic        b_tx_en, b_rx_valid, b_clr, b_locked, b_err;
  logic [31:0] b_tx_data, b_rx_data;
  logic [3:0]  b_tx_k, b_rx_k, b_disperr, b_nit, b_err_cnt, b_frame;

  occ_pattern_genchk #(.g_BYTES(4), .g_COMMA_PERIOD(8), .g_ERR_CNT_WIDTH(4), .g_LOSS_THRESH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .tx_en_i(b_tx_en), .tx_data_o(b_tx_data), .tx_charisk_o(b_tx_k),
    .rx_valid_i(b_rx_valid), .rx_data_i(b_rx_data), .rx_charisk_i(b_rx_k),
    .rx_disperr_i(b_disperr), .rx_notintable_i(b_nit), .clr_i(b_clr),
    .locked_o(b_locked), .err_o(b_err), .err_cnt_o(b_err_cnt), .frame_cnt_o(b_frame)
  );

  localparam logic [17:0] A_COMMA = {2'b10, 16'hBC95};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pattern word n as {K, data}: comma on every multiple of the period
  function automatic logic [17:0] a_word(input int unsigned n);
    if (n % 32 == 0) return A_COMMA;
    return {2'b00, 16'(n)};
  endfunction

  function automatic logic [35:0] b_word(input logic [31:0] n);
    if (n[2:0] == 3'd0) return {4'b1000, 32'hBC959595};
    return {4'b0000, n};
  endfunction

  task automatic a_send(input logic [17:0] w, input logic v, input logic [1:0] de, input logic c);
    a_rx_valid = v;
    a_rx_d     = w[15:0];
    a_rx_kd    = w[17:16];
    a_disperr  = de;
    a_clr      = c;
    step();
    a_rx_valid = 1'b0;
    a_disperr  = '0;
    a_clr      = 1'b0;
  endtask

  task automatic b_send(input logic [35:0] w, input logic c);
    b_rx_valid = 1'b1;
    b_rx_data  = w[31:0];
    b_rx_k     = w[35:32];
    b_clr      = c;
    step();
    b_rx_valid = 1'b0;
    b_clr      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lb = 1'b0;
    a_tx_en = 0; a_rx_valid = 0; a_rx_d = '0; a_rx_kd = '0; a_disperr = '0; a_nit = '0; a_clr = 0;
    b_tx_en = 0; b_rx_valid = 0; b_rx_data = '0; b_rx_k = '0; b_disperr = '0; b_nit = '0; b_clr = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic [1:0]  k;
  } gen_vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gen_vec_t gv[6];
    int       lock_n;
    int       err_pulses;
    logic [17:0] w;
    logic [31:0] bn;
    // random-run model state
    int          m_phase;
    int unsigned m_e, m_run, m_ec, m_fc, tb_n, burst;
    logic        m_err;

    gv[0] = '{1'b1, 16'hBC95, 2'b10};
    gv[1] = '{1'b1, 16'h0001, 2'b00};
    gv[2] = '{1'b0, 16'h0001, 2'b00};
    gv[3] = '{1'b1, 16'h0002, 2'b00};
    gv[4] = '{1'b0, 16'h0002, 2'b00};
    gv[5] = '{1'b1, 16'h0003, 2'b00};

    // Reset state
    do_reset();
    chk("rst_tx_data", 64'(a_tx_data), 64'(0));
    chk("rst_tx_k", 64'(a_tx_k), 64'(0));
    chk("rst_locked", 64'(a_locked), 64'(0));
    chk("rst_err", 64'(a_err), 64'(0));
    chk("rst_err_cnt", 64'(a_err_cnt), 64'(0));
    chk("rst_frame_cnt", 64'(a_frame), 64'(0));
    chk("rst_b_tx_data", 64'(b_tx_data), 64'(0));

    // Generator vector table, including tx_en_i hold cycles
    for (int i = 0; i < 6; i++) begin
      a_tx_en = gv[i].en;
      step();
      chk($sformatf("gen_data[%0d]", i), 64'(a_tx_data), 64'(gv[i].data));
      chk($sformatf("gen_k[%0d]", i), 64'(a_tx_k), 64'(gv[i].k));
    end

    // Loopback for 10000 cycles
    do_reset();
    lb = 1'b1;
    a_rx_valid = 1'b1;
    a_tx_en = 1'b1;
    err_pulses = 0;
    for (int c = 1; c <= 10000; c++) begin
      step();
      if (a_err) err_pulses++;
      if (c == 2) chk("lb_not_locked_after_comma", 64'(a_locked), 64'(0));
      if (c == 3) chk("lb_locked_after_seed", 64'(a_locked), 64'(1));
    end
    chk("lb_err_cnt", 64'(a_err_cnt), 64'(0));
    chk("lb_err_pulses", 64'(err_pulses), 64'(0));
    chk("lb_frame_cnt", 64'(a_frame), 64'(312));
    chk("lb_locked", 64'(a_locked), 64'(1));

    // Single corruption, loss of lock, relock, clear, disparity, reset while locked
    do_reset();
    a_tx_en = 1'b1;
    for (int n = 0; n < 10; n++) a_send(a_word(n), 1'b1, 2'b00, 1'b0);
    chk("hs_locked", 64'(a_locked), 64'(1));
    w = a_word(10) ^ 18'h00008;
    a_send(w, 1'b1, 2'b00, 1'b0);
    chk("single_err_pulse", 64'(a_err), 64'(1));
    chk("single_err_cnt", 64'(a_err_cnt), 64'(1));
    chk("single_locked", 64'(a_locked), 64'(1));
    a_send(a_word(11), 1'b1, 2'b00, 1'b0);
    chk("single_pulse_end", 64'(a_err), 64'(0));
    for (int n = 12; n < 16; n++) begin
      a_send(a_word(n) ^ 18'h00008, 1'b1, 2'b00, 1'b0);
      if (n == 14) chk("burst3_locked", 64'(a_locked), 64'(1));
    end
    chk("burst4_err_cnt", 64'(a_err_cnt), 64'(5));
    chk("burst4_unlocked", 64'(a_locked), 64'(0));
    lock_n = -1;
    for (int n = 16; n < 80; n++) begin
      a_send(a_word(n), 1'b1, 2'b00, 1'b0);
      if (a_locked) begin
        lock_n = n;
        break;
      end
    end
    chk("relock_word", 64'(lock_n), 64'(33));
    a_send(a_word(34) ^ 18'h00100, 1'b1, 2'b00, 1'b1);
    chk("clr_wins_err_cnt", 64'(a_err_cnt), 64'(0));
    chk("clr_keeps_lock", 64'(a_locked), 64'(1));
    a_send(a_word(35), 1'b1, 2'b00, 1'b0);
    a_send(a_word(36), 1'b1, 2'b01, 1'b0);
`ifdef OCC_PATTERN_DISPERR_EN
    chk("disperr_err_cnt", 64'(a_err_cnt), 64'(1));
`else
    chk("disperr_err_cnt", 64'(a_err_cnt), 64'(0));
`endif
    a_send(a_word(37), 1'b1, 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_locked", 64'(a_locked), 64'(0));
    chk("midrst_tx_data", 64'(a_tx_data), 64'(0));
    chk("midrst_err_cnt", 64'(a_err_cnt), 64'(0));
    chk("midrst_err", 64'(a_err), 64'(0));

    // Randomized run against the model
    do_reset();
    m_phase = 0; m_e = 0; m_run = 0; m_ec = 0; m_fc = 0; tb_n = 0; burst = 0;
    for (int c = 0; c < 4000; c++) begin
      logic v, cl, line_err;
      logic [1:0] de;
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 149) == 0);
      de = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (v) begin
        if ($urandom_range(0, 399) == 0) tb_n += $urandom_range(1, 100);
        w = a_word(tb_n);
        tb_n++;
        if ($urandom_range(0, 249) == 0) burst = 5;
        if (burst > 0) begin
          burst--;
          w = w ^ (18'd1 << $urandom_range(0, 17));
        end else if ($urandom_range(0, 29) == 0) begin
          w = w ^ (18'd1 << $urandom_range(0, 17));
        end
      end else begin
        w = 18'($urandom);
      end
`ifdef OCC_PATTERN_DISPERR_EN
      line_err = (de != 2'b00);
`else
      line_err = 1'b0;
`endif
      a_send(w, v, de, cl);
      m_err = 1'b0;
      if (v) begin
        if (m_phase == 0) begin
          if (w == A_COMMA) m_phase = 1;
        end else if (m_phase == 1) begin
          if (w[17:16] == 2'b00 && w[4:0] == 5'd1) begin
            m_phase = 2;
            m_e = int'(w[15:0]) + 1;
            m_run = 0;
          end else begin
            m_phase = 0;
          end
        end else begin
          if (w == a_word(m_e) && !line_err) begin
            m_run = 0;
            if (a_word(m_e) == A_COMMA && m_fc < 65535) m_fc++;
          end else begin
            m_err = 1'b1;
            if (m_ec < 65535) m_ec++;
            m_run++;
            if (m_run == 4) begin
              m_phase = 0;
              m_run = 0;
            end
          end
          m_e++;
        end
      end
      if (cl) begin
        m_ec = 0;
        m_fc = 0;
      end
      chk("rnd_locked", 64'(a_locked), 64'(m_phase == 2));
      chk("rnd_err", 64'(a_err), 64'(m_err));
      chk("rnd_err_cnt", 64'(a_err_cnt), 64'(m_ec));
      chk("rnd_frame_cnt", 64'(a_frame), 64'(m_fc));
    end

    // 4-byte instance: generator, wrap region, saturation and clear
    do_reset();
    b_tx_en = 1'b1;
    step();
    chk("b_gen_comma", 64'(b_tx_data), 64'(32'hBC959595));
    chk("b_gen_comma_k", 64'(b_tx_k), 64'(4'b1000));
    step();
    chk("b_gen_word1", 64'(b_tx_data), 64'(1));
    chk("b_gen_word1_k", 64'(b_tx_k), 64'(0));
    b_tx_en = 1'b0;
    b_send(b_word(32'h0), 1'b0);
    b_send(b_word(32'hFFFFFFF1), 1'b0);
    chk("b_seed_locked", 64'(b_locked), 64'(1));
    bn = 32'hFFFFFFF2;
    for (int i = 0; i < 31; i++) begin
      b_send(b_word(bn), 1'b0);
      bn = bn + 1;
    end
    chk("b_wrap_err_cnt", 64'(b_err_cnt), 64'(0));
    chk("b_wrap_frame_cnt", 64'(b_frame), 64'(4));
    chk("b_wrap_locked", 64'(b_locked), 64'(1));
    for (int i = 0; i < 20; i++) begin
      b_send(b_word(bn) ^ 36'h000000100, 1'b0);
      bn = bn + 1;
      b_send(b_word(bn), 1'b0);
      bn = bn + 1;
    end
    chk("b_sat_err_cnt", 64'(b_err_cnt), 64'(15));
    chk("b_sat_locked", 64'(b_locked), 64'(1));
    b_send(b_word(bn), 1'b1);
    chk("b_clr_err_cnt", 64'(b_err_cnt), 64'(0));
    chk("b_clr_frame_cnt", 64'(b_frame), 64'(0));
    chk("b_clr_locked", 64'(b_locked), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
